mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Memory responder for the pipelined core. It services the core's instruction-fetch port (rom_*) and data port (ram_*) from a single byte-wide synchronous external memory, arbitrating between the two and serialising each 32-bit access into byte transfers. It sits between the core top and the board memory, and drives a stall request into the core's pipeline controller while any access is outstanding.

## Interface
- No parameters. Address width is 32 bits; data word is 32 bits; memory lane is 8 bits.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rom_ce_i  in  1  instruction fetch request.
- rom_addr_i  in  32  fetch byte address.
- rom_data_o  out  32  fetched instruction; registered; holds its value until the next fetch completes.
- rom_done_o  out  1  one-cycle pulse; rom_data_o is valid in this cycle.
- ram_ce_i  in  1  data access request.
- ram_we_i  in  1  1 = write, 0 = read.
- ram_sel_i  in  4  byte-lane enables; bit k selects data[8k+7:8k].
- ram_addr_i  in  32  data byte address.
- ram_data_i  in  32  write data.
- ram_data_o  out  32  read data; registered; holds its value until the next read completes.
- ram_done_o  out  1  one-cycle pulse marking data-access completion.
- stallreq_o  out  1  combinational stall request to the pipeline controller.
- mem_a_o  out  32  external memory byte address.
- mem_dout_o  out  8  external write byte.
- mem_wr_o  out  1  external write strobe.
- mem_din_i  in  8  external read byte. It is valid in the cycle after its address is presented.

## Operation
- Word base address is {addr[31:2], 2'b00}. Lane k maps to base+k. Ordering is little-endian.
- FSM states:
  - IDLE. If (ram_ce_i & ~ram_ok), latch the ram request and go to RD (if ram_we_i = 0) or WR (if ram_we_i = 1). Otherwise, if (rom_ce_i & ~rom_ok), latch the rom request and go to RD. Data requests have priority over fetch.
  - RD: counter cnt runs 0..4.
    - For cnt = 0..3: mem_a_o = base+cnt.
    - For cnt = 1..4: capture mem_din_i into byte cnt-1 of the result.
    - After cnt = 4, go to DONE.
  - WR: counter cnt runs 0..3.
    - mem_a_o = base+cnt.
    - mem_dout_o = ram_data_i lane cnt (latched copy).
    - mem_wr_o = sel[cnt] (latched).
    - After cnt = 3, go to DONE.
  - DONE:
    - Pulse rom_done_o or ram_done_o according to the owner of the transaction.
    - Load the result into rom_data_o, or into ram_data_o for a ram read. A write leaves ram_data_o unchanged.
    - Set the owner's service flag (rom_ok or ram_ok), then go to IDLE.
- Outputs in IDLE and DONE: mem_a_o = 0, mem_wr_o = 0, mem_dout_o = 0.
- Stall logic:
  - stallreq_o = (ram_ce_i & ~ram_ok & ~ram_done_o) | (rom_ce_i & ~rom_ok & ~rom_done_o).
  - rom_ok and ram_ok are both cleared on any cycle in which stallreq_o = 0, i.e. when the pipeline advances.
  - This ensures a request that was already served is not re-serviced while the core stays stalled on the other port.
- ram_sel_i = 0000 with a write: runs 4 WR cycles with mem_wr_o = 0, then DONE.
- A request is latched at acceptance. Changes to ce/addr/data during a transaction are ignored. A transaction whose ce drops mid-flight still completes and pulses done.

## Timing
- Request accepted in cycle 0 (IDLE with the request present).
- Read latency:
  - Addresses are presented in cycles 1-4.
  - Captures happen at the ends of cycles 2-5.
  - done and valid data appear in cycle 6.
- Write latency: lanes in cycles 1-4; done in cycle 5.
- Both ports requested in cycle 0:
  - Ram read done in cycle 6. The FSM returns to IDLE in cycle 7.
  - The rom fetch is accepted in cycle 7 and completes in cycle 13.
  - stallreq_o stays 1 through cycle 12 and is 0 in cycle 13.
- Back-to-back operation: IDLE lasts at least one cycle between transactions.
- Reset (asynchronous, any state):
  - FSM returns to IDLE; cnt = 0; both service flags cleared.
  - rom_data_o = 0, ram_data_o = 0, both done outputs = 0.
  - mem_a_o = 0, mem_dout_o = 0, mem_wr_o = 0.
  - stallreq_o is forced to 0 while rst = 1.
  - An in-flight transaction is abandoned and no done pulse is produced.

## Test plan
- Fetch only: memory bytes at 0x100..0x103 = 13,05,10,00; rom_ce_i = 1, addr = 0x100. Required: rom_done_o in cycle 6, rom_data_o = 0x00100513, stallreq_o = 1 in cycles 0-5 and 0 in cycle 6.
- Byte write: ram_we_i = 1, sel = 0100, addr = 0x203, data = 0xAABBCCDD. Required: exactly one mem_wr_o pulse, at cycle 3, with mem_a_o = 0x202 and mem_dout_o = 0xBB. ram_done_o in cycle 5.
- Contention: rom and ram reads issued together. Required: ram serviced first (done in cycle 6), then rom (done in cycle 13). No re-service of ram while the core holds ram_ce_i through cycle 13.
- Zero-sel write: sel = 0000. Required: mem_wr_o never asserts; ram_done_o in cycle 5.
- Reset during a read at cycle 3:
  - Required: all outputs return to their reset values immediately and no done pulse occurs.
  - After release, a new fetch completes normally with 6-cycle latency.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// Core-side fetch/data ports and byte-wide external memory port of mem_ctrl.
// The master modport is the environment (core plus board memory); slave is mem_ctrl.
interface mem_ctrl_if;
   logic        rom_ce_i;
   logic [31:0] rom_addr_i;
   logic [31:0] rom_data_o;
   logic        rom_done_o;
   logic        ram_ce_i;
   logic        ram_we_i;
   logic [3:0]  ram_sel_i;
   logic [31:0] ram_addr_i;
   logic [31:0] ram_data_i;
   logic [31:0] ram_data_o;
   logic        ram_done_o;
   logic        stallreq_o;
   logic [31:0] mem_a_o;
   logic [7:0]  mem_dout_o;
   logic        mem_wr_o;
   logic [7:0]  mem_din_i;

   modport master (
      output rom_ce_i, rom_addr_i,
      output ram_ce_i, ram_we_i, ram_sel_i, ram_addr_i, ram_data_i,
      output mem_din_i,
      input  rom_data_o, rom_done_o, ram_data_o, ram_done_o, stallreq_o,
      input  mem_a_o, mem_dout_o, mem_wr_o
   );

   modport slave (
      input  rom_ce_i, rom_addr_i,
      input  ram_ce_i, ram_we_i, ram_sel_i, ram_addr_i, ram_data_i,
      input  mem_din_i,
      output rom_data_o, rom_done_o, ram_data_o, ram_done_o, stallreq_o,
      output mem_a_o, mem_dout_o, mem_wr_o
   );
endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates fetch and data ports onto one byte-wide synchronous memory,
// serialising each 32-bit access into four little-endian byte transfers.
module mem_ctrl (
   input logic       clk,
   input logic       rst,
   mem_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
   typedef enum logic {OWN_ROM, OWN_RAM} owner_t;

   state_t      state, state_d;
   owner_t      owner;
   logic [2:0]  cnt, cnt_d;
   logic [29:0] req_word;
   logic [31:0] req_wdata;
   logic [3:0]  req_sel;
   logic [23:0] rd_buf;
   logic [31:0] rom_data_q, ram_data_q;
   logic        rom_ok, ram_ok;
   logic        acc_ram, acc_rom;
   logic        rom_done, ram_done, stall;
   logic [31:0] lane_addr;
   logic [31:0] mem_a;
   logic [7:0]  mem_dout;
   logic        mem_wr;
   logic        unused_addr_lsbs;

   assign unused_addr_lsbs = ^{bus.rom_addr_i[1:0], bus.ram_addr_i[1:0]};

   assign lane_addr = {req_word, 2'b00} + {29'd0, cnt};
   assign rom_done  = (state == DONE) && (owner == OWN_ROM);
   assign ram_done  = (state == DONE) && (owner == OWN_RAM);
   assign stall     = ~rst & ((bus.ram_ce_i & ~ram_ok & ~ram_done) |
                              (bus.rom_ce_i & ~rom_ok & ~rom_done));

   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      acc_ram  = 1'b0;
      acc_rom  = 1'b0;
      mem_a    = '0;
      mem_dout = '0;
      mem_wr   = 1'b0;
      case (state)
         IDLE: begin
            cnt_d = '0;
            if (bus.ram_ce_i && !ram_ok) begin
               acc_ram = 1'b1;
               state_d = bus.ram_we_i ? WR : RD;
            end else if (bus.rom_ce_i && !rom_ok) begin
               acc_rom = 1'b1;
               state_d = RD;
            end
         end
         RD: begin
            if (cnt != 3'd4) mem_a = lane_addr;
            if (cnt == 3'd4) begin
               state_d = DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt + 3'd1;
            end
         end
         WR: begin
            mem_a    = lane_addr;
            mem_dout = req_wdata[{cnt[1:0], 3'b000} +: 8];
            mem_wr   = req_sel[cnt[1:0]];
            if (cnt == 3'd3) begin
               state_d = DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt + 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         owner      <= OWN_ROM;
         req_word   <= '0;
         req_wdata  <= '0;
         req_sel    <= '0;
         rd_buf     <= '0;
         rom_data_q <= '0;
         ram_data_q <= '0;
         rom_ok     <= 1'b0;
         ram_ok     <= 1'b0;
      end else begin
         cnt <= cnt_d;
         if (acc_ram) begin
            owner     <= OWN_RAM;
            req_word  <= bus.ram_addr_i[31:2];
            req_wdata <= bus.ram_data_i;
            req_sel   <= bus.ram_sel_i;
         end else if (acc_rom) begin
            owner    <= OWN_ROM;
            req_word <= bus.rom_addr_i[31:2];
         end
         if (state == RD && cnt != 3'd0 && cnt != 3'd4)
            rd_buf[{cnt[1:0] - 2'd1, 3'b000} +: 8] <= bus.mem_din_i;
         // Last byte goes straight to the output so data is valid in the DONE cycle.
         if (state == RD && cnt == 3'd4) begin
            if (owner == OWN_ROM) rom_data_q <= {bus.mem_din_i, rd_buf};
            else                  ram_data_q <= {bus.mem_din_i, rd_buf};
         end
         // Pipeline advance clears both flags and takes priority over setting one.
         if (!stall) begin
            rom_ok <= 1'b0;
            ram_ok <= 1'b0;
         end else if (state == DONE) begin
            if (owner == OWN_ROM) rom_ok <= 1'b1;
            else                  ram_ok <= 1'b1;
         end
      end
   end

   assign bus.rom_data_o = rom_data_q;
   assign bus.ram_data_o = ram_data_q;
   assign bus.rom_done_o = rom_done;
   assign bus.ram_done_o = ram_done;
   assign bus.stallreq_o = stall;
   assign bus.mem_a_o    = mem_a;
   assign bus.mem_dout_o = mem_dout;
   assign bus.mem_wr_o   = mem_wr;

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomised self-checking bench for mem_ctrl against a byte-array memory
// model and a word-level reference of what each access must return.
module tb_mem_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_ctrl_if bus ();

   mem_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [7:0] mem     [0:4095];
   logic [7:0] ref_mem [0:4095];

   always @(posedge clk) begin
      if (bus.mem_wr_o) mem[bus.mem_a_o[11:0]] <= bus.mem_dout_o;
      bus.mem_din_i <= mem[bus.mem_a_o[11:0]];
   end

   int total = 0;
   int bad   = 0;

   int          rom_done_cnt, rom_done_cyc, ram_done_cnt, ram_done_cyc;
   logic [31:0] rom_word, ram_word;
   logic [31:0] stall_bits;
   int          wr_cnt, wr_cyc;
   logic [31:0] wr_a;
   logic [7:0]  wr_d;
   logic [31:0] exp_rom_data = '0;
   logic [31:0] exp_ram_data = '0;

   function automatic logic [31:0] ref_word(input logic [31:0] a);
      logic [11:0] b;
      b = {a[11:2], 2'b00};
      return {ref_mem[b + 12'd3], ref_mem[b + 12'd2], ref_mem[b + 12'd1], ref_mem[b]};
   endfunction

   // Entered and left #1 after a rising edge; cycle 0 is the cycle the request appears.
   task automatic run_txn(input logic rom_ce, input logic [31:0] rom_addr,
                          input logic ram_ce, input logic we, input logic [3:0] sel,
                          input logic [31:0] ram_addr, input logic [31:0] wdata,
                          input int hold_rom, input int hold_ram, input int tot,
                          input logic scramble);
      rom_done_cnt = 0; rom_done_cyc = -1; ram_done_cnt = 0; ram_done_cyc = -1;
      wr_cnt = 0; wr_cyc = -1; wr_a = '0; wr_d = '0; stall_bits = '0;
      rom_word = '0; ram_word = '0;
      for (int c = 0; c < tot; c++) begin
         bus.rom_ce_i = rom_ce && (c < hold_rom);
         bus.ram_ce_i = ram_ce && (c < hold_ram);
         if (c == 0 || !scramble) begin
            bus.rom_addr_i = rom_addr;
            bus.ram_addr_i = ram_addr;
            bus.ram_we_i   = we;
            bus.ram_sel_i  = sel;
            bus.ram_data_i = wdata;
         end else begin
            bus.rom_addr_i = $urandom;
            bus.ram_addr_i = $urandom;
            bus.ram_we_i   = 1'($urandom);
            bus.ram_sel_i  = 4'($urandom);
            bus.ram_data_i = $urandom;
         end
         @(negedge clk);
         stall_bits[c] = bus.stallreq_o;
         if (bus.rom_done_o) begin
            rom_done_cnt++; rom_done_cyc = c; rom_word = bus.rom_data_o;
         end
         if (bus.ram_done_o) begin
            ram_done_cnt++; ram_done_cyc = c; ram_word = bus.ram_data_o;
         end
         if (bus.mem_wr_o) begin
            wr_cnt++; wr_cyc = c; wr_a = bus.mem_a_o; wr_d = bus.mem_dout_o;
         end
         @(posedge clk);
         #1;
      end
      bus.rom_ce_i = 1'b0;
      bus.ram_ce_i = 1'b0;
   endtask

   task automatic test_reset;
      bus.rom_ce_i = 1'b1;
      bus.ram_ce_i = 1'b1;
      #1;
      total++; if (bus.stallreq_o !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", bus.stallreq_o); end
      total++; if (bus.rom_done_o !== 1'b0 || bus.ram_done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%b%b exp=00", bus.rom_done_o, bus.ram_done_o); end
      total++; if (bus.rom_data_o !== 32'h0 || bus.ram_data_o !== 32'h0) begin bad++; $display("FAIL reset_data got=%h/%h exp=0", bus.rom_data_o, bus.ram_data_o); end
      total++; if (bus.mem_a_o !== 32'h0 || bus.mem_wr_o !== 1'b0 || bus.mem_dout_o !== 8'h0) begin bad++; $display("FAIL reset_mem got a=%h wr=%b d=%h exp=0", bus.mem_a_o, bus.mem_wr_o, bus.mem_dout_o); end
      bus.rom_ce_i = 1'b0;
      bus.ram_ce_i = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_fetch;
      run_txn(1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 7, 0, 9, 1'b1);
      exp_rom_data = ref_word(32'h100);
      total++; if (rom_done_cnt != 1 || rom_done_cyc != 6) begin bad++; $display("FAIL fetch_done got cnt=%0d cyc=%0d exp 1/6", rom_done_cnt, rom_done_cyc); end
      total++; if (rom_word !== 32'h00100513) begin bad++; $display("FAIL fetch_data got=%h exp=00100513", rom_word); end
      total++; if (stall_bits[8:0] !== 9'h03F) begin bad++; $display("FAIL fetch_stall got=%b exp=%b", stall_bits[8:0], 9'h03F); end
      total++; if (ram_done_cnt != 0) begin bad++; $display("FAIL fetch_no_ram_done got=%0d exp=0", ram_done_cnt); end
   endtask

   task automatic test_write_byte;
      logic [31:0] d;
      d = 32'hAABBCCDD;
      run_txn(1'b0, 32'h0, 1'b1, 1'b1, 4'b0100, 32'h203, d, 0, 6, 8, 1'b1);
      ref_mem[12'h202] = 8'hBB;
      total++; if (wr_cnt != 1 || wr_cyc != 3) begin bad++; $display("FAIL wbyte_pulse got cnt=%0d cyc=%0d exp 1/3", wr_cnt, wr_cyc); end
      total++; if (wr_a !== 32'h202 || wr_d !== 8'hBB) begin bad++; $display("FAIL wbyte_lane got a=%h d=%h exp 202/bb", wr_a, wr_d); end
      total++; if (ram_done_cnt != 1 || ram_done_cyc != 5) begin bad++; $display("FAIL wbyte_done got cnt=%0d cyc=%0d exp 1/5", ram_done_cnt, ram_done_cyc); end
      total++; if (bus.ram_data_o !== exp_ram_data) begin bad++; $display("FAIL wbyte_hold got=%h exp=%h", bus.ram_data_o, exp_ram_data); end
      run_txn(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h201, 32'h0, 0, 7, 8, 1'b1);
      exp_ram_data = ref_word(32'h200);
      total++; if (ram_done_cyc != 6 || ram_word !== exp_ram_data) begin bad++; $display("FAIL wbyte_readback got cyc=%0d d=%h exp 6/%h", ram_done_cyc, ram_word, exp_ram_data); end
   endtask

   task automatic test_zero_sel;
      run_txn(1'b0, 32'h0, 1'b1, 1'b1, 4'b0000, 32'h300, 32'h12345678, 0, 6, 8, 1'b0);
      total++; if (wr_cnt != 0) begin bad++; $display("FAIL zsel_wr got=%0d exp=0", wr_cnt); end
      total++; if (ram_done_cnt != 1 || ram_done_cyc != 5) begin bad++; $display("FAIL zsel_done got cnt=%0d cyc=%0d exp 1/5", ram_done_cnt, ram_done_cyc); end
      total++; if (stall_bits[7:0] !== 8'h1F) begin bad++; $display("FAIL zsel_stall got=%b exp=%b", stall_bits[7:0], 8'h1F); end
   endtask

   task automatic test_contention;
      logic [31:0] ra;
      ra = {20'h0, 12'($urandom_range(0, 4095))};
      run_txn(1'b1, 32'h100, 1'b1, 1'b0, 4'hF, ra, 32'h0, 14, 14, 16, 1'b0);
      exp_ram_data = ref_word(ra);
      exp_rom_data = ref_word(32'h100);
      total++; if (ram_done_cnt != 1 || ram_done_cyc != 6) begin bad++; $display("FAIL cont_ram_done got cnt=%0d cyc=%0d exp 1/6", ram_done_cnt, ram_done_cyc); end
      total++; if (rom_done_cnt != 1 || rom_done_cyc != 13) begin bad++; $display("FAIL cont_rom_done got cnt=%0d cyc=%0d exp 1/13", rom_done_cnt, rom_done_cyc); end
      total++; if (stall_bits[15:0] !== 16'h1FFF) begin bad++; $display("FAIL cont_stall got=%b exp=%b", stall_bits[15:0], 16'h1FFF); end
      total++; if (ram_word !== exp_ram_data || rom_word !== exp_rom_data) begin bad++; $display("FAIL cont_data got=%h/%h exp=%h/%h", ram_word, rom_word, exp_ram_data, exp_rom_data); end
   endtask

   task automatic test_random;
      int unsigned op;
      logic [31:0] a, d, expw;
      logic [3:0]  s;
      logic [11:0] b;
      for (int n = 0; n < 30; n++) begin
         op = $urandom_range(0, 2);
         a  = {20'h0, 12'($urandom_range(0, 4095))};
         d  = $urandom;
         s  = 4'($urandom);
         b  = {a[11:2], 2'b00};
         if (op == 0) begin
            run_txn(1'b0, 32'h0, 1'b1, 1'b0, s, a, d, 0, 7, 8, 1'b1);
            exp_ram_data = ref_word(a);
            total++; if (ram_done_cnt != 1 || ram_done_cyc != 6 || ram_word !== exp_ram_data) begin bad++; $display("FAIL rnd_read n=%0d got cyc=%0d d=%h exp 6/%h", n, ram_done_cyc, ram_word, exp_ram_data); end
            total++; if (stall_bits[7:0] !== 8'h3F) begin bad++; $display("FAIL rnd_read_stall n=%0d got=%b exp=%b", n, stall_bits[7:0], 8'h3F); end
         end else if (op == 1) begin
            run_txn(1'b0, 32'h0, 1'b1, 1'b1, s, a, d, 0, 6, 8, 1'b1);
            for (int k = 0; k < 4; k++)
               if (s[k]) ref_mem[b + 12'(k)] = d[8*k +: 8];
            total++; if (ram_done_cnt != 1 || ram_done_cyc != 5 || wr_cnt != $countones(s)) begin bad++; $display("FAIL rnd_write n=%0d got cyc=%0d wr=%0d exp 5/%0d", n, ram_done_cyc, wr_cnt, $countones(s)); end
            total++; if (bus.ram_data_o !== exp_ram_data) begin bad++; $display("FAIL rnd_write_hold n=%0d got=%h exp=%h", n, bus.ram_data_o, exp_ram_data); end
         end else begin
            run_txn(1'b1, a, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 7, 0, 8, 1'b1);
            expw = ref_word(a);
            exp_rom_data = expw;
            total++; if (rom_done_cnt != 1 || rom_done_cyc != 6 || rom_word !== expw) begin bad++; $display("FAIL rnd_fetch n=%0d got cyc=%0d d=%h exp 6/%h", n, rom_done_cyc, rom_word, expw); end
            total++; if (bus.ram_data_o !== exp_ram_data) begin bad++; $display("FAIL rnd_fetch_ramhold n=%0d got=%h exp=%h", n, bus.ram_data_o, exp_ram_data); end
         end
      end
   endtask

   task automatic test_reset_mid;
      int dones;
      bus.rom_addr_i = 32'h100;
      bus.rom_ce_i   = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      #2 rst = 1'b1;
      #1;
      exp_rom_data = '0;
      exp_ram_data = '0;
      total++; if (bus.rom_data_o !== 32'h0 || bus.ram_data_o !== 32'h0) begin bad++; $display("FAIL rmid_data got=%h/%h exp=0", bus.rom_data_o, bus.ram_data_o); end
      total++; if (bus.stallreq_o !== 1'b0 || bus.rom_done_o !== 1'b0) begin bad++; $display("FAIL rmid_ctl got stall=%b done=%b exp=00", bus.stallreq_o, bus.rom_done_o); end
      total++; if (bus.mem_a_o !== 32'h0 || bus.mem_wr_o !== 1'b0 || bus.mem_dout_o !== 8'h0) begin bad++; $display("FAIL rmid_mem got a=%h wr=%b d=%h exp=0", bus.mem_a_o, bus.mem_wr_o, bus.mem_dout_o); end
      dones = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (bus.rom_done_o || bus.ram_done_o) dones++;
      end
      bus.rom_ce_i = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      total++; if (dones != 0) begin bad++; $display("FAIL rmid_no_done got=%0d exp=0", dones); end
      @(posedge clk); #1;
      run_txn(1'b1, 32'h102, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 7, 0, 8, 1'b0);
      exp_rom_data = ref_word(32'h100);
      total++; if (rom_done_cnt != 1 || rom_done_cyc != 6 || rom_word !== exp_rom_data) begin bad++; $display("FAIL rmid_refetch got cyc=%0d d=%h exp 6/%h", rom_done_cyc, rom_word, exp_rom_data); end
   endtask

   initial begin
      logic [7:0] v;
      bus.rom_ce_i = 1'b0; bus.rom_addr_i = '0;
      bus.ram_ce_i = 1'b0; bus.ram_we_i = 1'b0; bus.ram_sel_i = '0;
      bus.ram_addr_i = '0; bus.ram_data_i = '0;
      for (int i = 0; i < 4096; i++) begin
         v = 8'($urandom);
         mem[i] = v;
         ref_mem[i] = v;
      end
      mem[12'h100] = 8'h13; ref_mem[12'h100] = 8'h13;
      mem[12'h101] = 8'h05; ref_mem[12'h101] = 8'h05;
      mem[12'h102] = 8'h10; ref_mem[12'h102] = 8'h10;
      mem[12'h103] = 8'h00; ref_mem[12'h103] = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      test_reset;
      test_fetch;
      test_write_byte;
      test_zero_sel;
      test_contention;
      test_random;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
